ping_pong_rd_ctrl: RTL and testbench
====================================

PING_PONG_RD_CTRL -- requirements
Module: ping_pong_rd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, meaning bank address width.
REQ-002 SHALL have parameter INNER_BLOCKS, default 2, meaning INNER_DIMENSION/BLOCK_SIZE, the k-steps per output block.
REQ-003 SHALL have parameter COL_BLOCKS, default 2, meaning output-block columns per bank.
REQ-004 SHALL have parameter ROW_PAIRS, default 1, meaning output-row pairs per bank.
REQ-005 SHALL have port clk  input  1  the single clock; all state is clocked on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port bank_full  input  2  per-bank level from the writer: the bank is filled and may be read.
REQ-008 SHALL have port systolic_finish_wrap  input  1  pulse: the systolic array consumed one k-step.
REQ-009 SHALL have port acc_done_wrap  input  1  level: the accumulator finished one output block.
REQ-010 SHALL have port bank_release  output  2  one-cycle pulse per bank: the reader has finished that bank.
REQ-011 SHALL have port rd_bank  output  1  index of the bank currently being read.
REQ-012 SHALL have port rd_en  output  1  read enable for west port A, west port B and north port B.
REQ-013 SHALL have ports w_addra, w_addrb, n_addrb  output  ADDR_WIDTH  read addresses: west even row, west odd row, north.
REQ-014 SHALL have port enable_matmul  output  1  high while operands are valid for the array.
REQ-015 SHALL have port internal_reset_acc  output  1  accumulator clear request.

Function
REQ-016 SHALL implement the FSM IDLE -> WAIT_BANK -> PREFETCH -> RUN -> RELEASE -> WAIT_BANK.
REQ-017 SHALL leave IDLE on the first cycle after reset deassertion and enter WAIT_BANK with rd_bank=0.
REQ-018 SHALL go from WAIT_BANK to PREFETCH only when bank_full[rd_bank]=1; the other bank's flag SHALL be ignored.
REQ-019 SHALL hold PREFETCH for exactly 1 cycle with rd_en=1 and the k=0 addresses, to cover the 1-cycle BRAM read latency.
REQ-020 SHALL assert enable_matmul=1 throughout RUN and 0 in every other state.
REQ-021 SHALL compute the addresses as:
- w_addra = k + INNER_BLOCKS*(2*row)
- w_addrb = k + INNER_BLOCKS*(2*row+1)
- n_addrb = k + INNER_BLOCKS*col
- arithmetic is unsigned, truncated to ADDR_WIDTH.
REQ-022 SHALL, on systolic_finish_wrap in RUN, advance k, wrapping from INNER_BLOCKS-1 to 0.
REQ-023 SHALL, on the rising edge of acc_done_wrap in RUN:
- advance col;
- at COL_BLOCKS-1, clear col and advance row;
- pulse internal_reset_acc high for 1 cycle.
REQ-024 SHALL go to RELEASE when an acc_done_wrap rising edge occurs with row=ROW_PAIRS-1 and col=COL_BLOCKS-1.
REQ-025 SHALL, in RELEASE (1 cycle):
- pulse bank_release[rd_bank];
- clear k, row and col;
- toggle rd_bank;
- go to WAIT_BANK.
REQ-026 SHALL apply simultaneous systolic_finish_wrap and acc_done_wrap rising edges in the same cycle, with k wrapping to 0.
REQ-027 SHALL ignore systolic_finish_wrap and acc_done_wrap outside RUN; the acc_done_wrap edge detector SHALL still track the input.
REQ-028 SHALL hold rd_en=1 in PREFETCH and RUN and 0 otherwise.

Reset
REQ-029 SHALL, while rst=1, asynchronously force:
- state=IDLE, rd_bank=0, k=row=col=0;
- every output to 0;
- the edge-detect register to 0.
REQ-030 SHALL, on reset mid-RUN, discard progress without pulsing bank_release and restart at bank 0.

Configuration
REQ-031 SHALL, with PING_PONG_RD_PERF_EN defined, add output stall_cycles (32 bits, saturating), incremented each cycle spent in WAIT_BANK and cleared by rst.
REQ-032 SHALL, without PING_PONG_RD_PERF_EN, have no stall_cycles port and no counter logic.

Structure
REQ-033 SHALL take the state enum typedef (rd_state_t) and the bank index typedef from the shared package ping_pong_pkg, which the write controller also uses.
REQ-034 SHALL be a single module apart from one sub-module, ping_pong_addr_gen, which holds the k/row/col counters and the address arithmetic.

Verification (defaults: INNER_BLOCKS=2, COL_BLOCKS=2, ROW_PAIRS=1)
REQ-035 SHALL check: bank_full=00 for 20 cycles -> state stays WAIT_BANK, enable_matmul=0, rd_en=0.
REQ-036 SHALL check: bank_full=01, then 2 finish pulses and 1 acc_done edge -> addresses (a,b,n) = (0,2,0), (1,3,1), then col=1 giving (0,2,2).
REQ-037 SHALL check: a full bank-0 pass (4 finish pulses, 2 acc_done edges) -> bank_release=01 for exactly 1 cycle, then rd_bank=1.
REQ-038 SHALL check: finish pulse and acc_done edge in the same cycle at k=1 -> k=0 and col advances by 1.
REQ-039 SHALL check: rst asserted mid-RUN at col=1 -> all outputs 0 immediately, no release pulse, and rd_bank=0 after reset.
REQ-040 SHALL check: PING_PONG_RD_PERF_EN defined, 7 cycles in WAIT_BANK -> stall_cycles=7.

Source files
------------

// File: rtl/ping_pong_pkg.sv
// Types shared by the ping-pong buffer read and write controllers.
// Holds the reader state enum, the bank index type and small sizing helpers.
package ping_pong_pkg;

    localparam int unsigned NumBanks = 2;

    typedef logic bank_t;

    typedef enum logic [2:0] {
        StIdle,
        StWaitBank,
        StPrefetch,
        StRun,
        StRelease
    } rd_state_t;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bank_t other_bank(input bank_t b);
        return ~b;
    endfunction

endpackage

// File: rtl/ping_pong_addr_gen.sv
// k/row/col block counters and BRAM read address generation for the ping-pong reader.
// Addresses are registered from the next counter values, so they follow a step on the same edge.
module ping_pong_addr_gen
    import ping_pong_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned INNER_BLOCKS = 2,
    parameter int unsigned COL_BLOCKS   = 2,
    parameter int unsigned ROW_PAIRS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  k_step,
    input  logic                  blk_step,
    output logic                  last_blk,
    output logic [ADDR_WIDTH-1:0] w_addra,
    output logic [ADDR_WIDTH-1:0] w_addrb,
    output logic [ADDR_WIDTH-1:0] n_addrb
);

    localparam int unsigned KW = cnt_width(INNER_BLOCKS);
    localparam int unsigned CW = cnt_width(COL_BLOCKS);
    localparam int unsigned RW = cnt_width(ROW_PAIRS);

    localparam logic [KW-1:0] KMax = KW'(INNER_BLOCKS - 1);
    localparam logic [CW-1:0] CMax = CW'(COL_BLOCKS - 1);
    localparam logic [RW-1:0] RMax = RW'(ROW_PAIRS - 1);

    localparam logic [ADDR_WIDTH-1:0] IbAddr = ADDR_WIDTH'(INNER_BLOCKS);

    logic [KW-1:0] k, k_d;
    logic [CW-1:0] col, col_d;
    logic [RW-1:0] row, row_d;

    logic [ADDR_WIDTH-1:0] addra_d, addrb_d, naddr_d;

    always_comb begin
        k_d   = k;
        col_d = col;
        row_d = row;
        if (clear) begin
            k_d   = '0;
            col_d = '0;
            row_d = '0;
        end else begin
            if (k_step) begin
                k_d = (k == KMax) ? '0 : k + 1'b1;
            end
            if (blk_step) begin
                if (col == CMax) begin
                    col_d = '0;
                    row_d = (row == RMax) ? '0 : row + 1'b1;
                end else begin
                    col_d = col + 1'b1;
                end
            end
        end
    end

    // Modulo 2^ADDR_WIDTH arithmetic throughout; odd row is one k-stride past the even row.
    always_comb begin
        addra_d = ADDR_WIDTH'(k_d) + IbAddr * ADDR_WIDTH'({row_d, 1'b0});
        addrb_d = addra_d + IbAddr;
        naddr_d = ADDR_WIDTH'(k_d) + IbAddr * ADDR_WIDTH'(col_d);
    end

    assign last_blk = (row == RMax) && (col == CMax);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k       <= '0;
            col     <= '0;
            row     <= '0;
            w_addra <= '0;
            w_addrb <= '0;
            n_addrb <= '0;
        end else begin
            k       <= k_d;
            col     <= col_d;
            row     <= row_d;
            w_addra <= addra_d;
            w_addrb <= addrb_d;
            n_addrb <= naddr_d;
        end
    end

endmodule

// File: rtl/ping_pong_rd_ctrl.sv
// Ping-pong buffer read controller: waits for a full bank, streams it to the systolic array,
// then releases it and moves to the other bank. Optional PING_PONG_RD_PERF_EN adds stall_cycles.
module ping_pong_rd_ctrl
    import ping_pong_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned INNER_BLOCKS = 2,
    parameter int unsigned COL_BLOCKS   = 2,
    parameter int unsigned ROW_PAIRS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NumBanks-1:0]   bank_full,
    input  logic                  systolic_finish_wrap,
    input  logic                  acc_done_wrap,
    output logic [NumBanks-1:0]   bank_release,
    output bank_t                 rd_bank,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] w_addra,
    output logic [ADDR_WIDTH-1:0] w_addrb,
    output logic [ADDR_WIDTH-1:0] n_addrb,
    output logic                  enable_matmul,
`ifdef PING_PONG_RD_PERF_EN
    output logic [31:0]           stall_cycles,
`endif
    output logic                  internal_reset_acc
);

    rd_state_t state;
    logic      acc_prev;
    logic      acc_rise;
    logic      k_step;
    logic      blk_step;
    logic      clear;
    logic      last_blk;

    assign acc_rise = acc_done_wrap & ~acc_prev;
    assign k_step   = (state == StRun) & systolic_finish_wrap;
    assign blk_step = (state == StRun) & acc_rise;
    assign clear    = (state == StRelease);

    ping_pong_addr_gen #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .INNER_BLOCKS (INNER_BLOCKS),
        .COL_BLOCKS   (COL_BLOCKS),
        .ROW_PAIRS    (ROW_PAIRS)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .k_step   (k_step),
        .blk_step (blk_step),
        .last_blk (last_blk),
        .w_addra  (w_addra),
        .w_addrb  (w_addrb),
        .n_addrb  (n_addrb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= StIdle;
            rd_bank            <= '0;
            rd_en              <= 1'b0;
            enable_matmul      <= 1'b0;
            internal_reset_acc <= 1'b0;
            bank_release       <= '0;
            acc_prev           <= 1'b0;
        end else begin
            // Edge detector tracks the input in every state.
            acc_prev           <= acc_done_wrap;
            internal_reset_acc <= 1'b0;
            bank_release       <= '0;
            unique case (state)
                StIdle: begin
                    state <= StWaitBank;
                end
                StWaitBank: begin
                    if (bank_full[rd_bank]) begin
                        state <= StPrefetch;
                        rd_en <= 1'b1;
                    end
                end
                StPrefetch: begin
                    state         <= StRun;
                    enable_matmul <= 1'b1;
                end
                StRun: begin
                    if (blk_step) begin
                        internal_reset_acc <= 1'b1;
                        if (last_blk) begin
                            state                 <= StRelease;
                            rd_en                 <= 1'b0;
                            enable_matmul         <= 1'b0;
                            bank_release[rd_bank] <= 1'b1;
                        end
                    end
                end
                StRelease: begin
                    state   <= StWaitBank;
                    rd_bank <= other_bank(rd_bank);
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

`ifdef PING_PONG_RD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if ((state == StWaitBank) && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    // Stall counter not built in this configuration.
`endif

endmodule

// File: tb/tb_ping_pong_rd_ctrl.sv
// Directed bench for ping_pong_rd_ctrl at default sizing (INNER_BLOCKS=2, COL_BLOCKS=2, ROW_PAIRS=1).
// Checks the stall counter too when PING_PONG_RD_PERF_EN is defined.
module tb_ping_pong_rd_ctrl;
    import ping_pong_pkg::*;

    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    bank_full = 2'b00;
    logic          fin = 1'b0;
    logic          acc = 1'b0;
    logic [1:0]    bank_release;
    bank_t         rd_bank;
    logic          rd_en;
    logic [AW-1:0] w_addra, w_addrb, n_addrb;
    logic          enable_matmul;
    logic          internal_reset_acc;
`ifdef PING_PONG_RD_PERF_EN
    logic [31:0]   stall_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ping_pong_rd_ctrl #(
        .ADDR_WIDTH   (AW),
        .INNER_BLOCKS (2),
        .COL_BLOCKS   (2),
        .ROW_PAIRS    (1)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .bank_full            (bank_full),
        .systolic_finish_wrap (fin),
        .acc_done_wrap        (acc),
        .bank_release         (bank_release),
        .rd_bank              (rd_bank),
        .rd_en                (rd_en),
        .w_addra              (w_addra),
        .w_addrb              (w_addrb),
        .n_addrb              (n_addrb),
        .enable_matmul        (enable_matmul),
`ifdef PING_PONG_RD_PERF_EN
        .stall_cycles         (stall_cycles),
`endif
        .internal_reset_acc   (internal_reset_acc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_addr(input string tag, input int a, input int b, input int n);
        check({tag, "_w_addra"}, 32'(w_addra), 32'(a));
        check({tag, "_w_addrb"}, 32'(w_addrb), 32'(b));
        check({tag, "_n_addrb"}, 32'(n_addrb), 32'(n));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bank_release"}, 32'(bank_release), 32'd0);
        check({tag, "_rd_bank"}, 32'(rd_bank), 32'd0);
        check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        check({tag, "_enable_matmul"}, 32'(enable_matmul), 32'd0);
        check({tag, "_reset_acc"}, 32'(internal_reset_acc), 32'd0);
        check_addr(tag, 0, 0, 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset_state", 32'(dut.state), 32'(StIdle));

        rst = 1'b0;
        tick();
        check("idle_exit_state", 32'(dut.state), 32'(StWaitBank));
        check("idle_exit_rd_bank", 32'(rd_bank), 32'd0);

        // No bank full for 20 cycles
        repeat (7) tick();
`ifdef PING_PONG_RD_PERF_EN
        check("stall_cycles_7", stall_cycles, 32'd7);
`endif
        repeat (13) tick();
        check("wait20_state", 32'(dut.state), 32'(StWaitBank));
        check("wait20_rd_en", 32'(rd_en), 32'd0);
        check("wait20_enable", 32'(enable_matmul), 32'd0);

        // Other bank's flag must be ignored
        bank_full = 2'b10;
        repeat (3) tick();
        check("other_bank_state", 32'(dut.state), 32'(StWaitBank));
        check("other_bank_rd_en", 32'(rd_en), 32'd0);

        // Bank 0 pass
        bank_full = 2'b01;
        tick();
        check("prefetch_state", 32'(dut.state), 32'(StPrefetch));
        check("prefetch_rd_en", 32'(rd_en), 32'd1);
        check("prefetch_enable", 32'(enable_matmul), 32'd0);
        check_addr("prefetch", 0, 2, 0);
        tick();
        check("run_state", 32'(dut.state), 32'(StRun));
        check("run_enable", 32'(enable_matmul), 32'd1);
        check("run_rd_en", 32'(rd_en), 32'd1);
        check_addr("run_k0", 0, 2, 0);

        fin = 1'b1; tick(); fin = 1'b0;
        check_addr("k1_col0", 1, 3, 1);
        fin = 1'b1; tick(); fin = 1'b0;
        check_addr("k0_wrap", 0, 2, 0);
        acc = 1'b1; tick(); acc = 1'b0;
        check_addr("col1", 0, 2, 2);
        check("col1_reset_acc", 32'(internal_reset_acc), 32'd1);
        tick();
        check("reset_acc_pulse_end", 32'(internal_reset_acc), 32'd0);
        check("still_run_enable", 32'(enable_matmul), 32'd1);

        fin = 1'b1; tick(); fin = 1'b0;
        check_addr("k1_col1", 1, 3, 3);
        fin = 1'b1; tick(); fin = 1'b0;
        check_addr("k0_col1", 0, 2, 2);
        acc = 1'b1; tick(); acc = 1'b0;
        check("release_state", 32'(dut.state), 32'(StRelease));
        check("release_pulse", 32'(bank_release), 32'b01);
        check("release_rd_bank", 32'(rd_bank), 32'd0);
        check("release_enable", 32'(enable_matmul), 32'd0);
        check("release_rd_en", 32'(rd_en), 32'd0);
        tick();
        check("post_release_pulse", 32'(bank_release), 32'b00);
        check("post_release_rd_bank", 32'(rd_bank), 32'd1);
        check("post_release_state", 32'(dut.state), 32'(StWaitBank));
        tick();
        check("wait_bank1_state", 32'(dut.state), 32'(StWaitBank));
        check("wait_bank1_pulse", 32'(bank_release), 32'b00);

        // Bank 1 pass: simultaneous finish and acc edge at k=1
        bank_full = 2'b10;
        tick();
        check("b1_prefetch_state", 32'(dut.state), 32'(StPrefetch));
        tick();
        check("b1_run_enable", 32'(enable_matmul), 32'd1);
        fin = 1'b1; tick(); fin = 1'b0;
        check_addr("b1_k1", 1, 3, 1);
        fin = 1'b1; acc = 1'b1; tick(); fin = 1'b0; acc = 1'b0;
        check_addr("b1_both", 0, 2, 2);
        check("b1_both_reset_acc", 32'(internal_reset_acc), 32'd1);
        check("b1_both_state", 32'(dut.state), 32'(StRun));

        // Reset mid-RUN at col=1
        rst = 1'b1;
        #1;
        check_all_zero("midrun_rst");
        repeat (2) begin
            tick();
            check("midrun_rst_no_release", 32'(bank_release), 32'd0);
        end
        rst = 1'b0;
        tick();
        check("after_rst_state", 32'(dut.state), 32'(StWaitBank));
        check("after_rst_rd_bank", 32'(rd_bank), 32'd0);
        check("after_rst_release", 32'(bank_release), 32'd0);
        tick();
        check("after_rst_rd_en", 32'(rd_en), 32'd0);
        bank_full = 2'b01;
        tick();
        check("restart_bank0_rd_en", 32'(rd_en), 32'd1);
        check("restart_bank0_rd_bank", 32'(rd_bank), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
